// File: rtl/dma_pkg.sv
// dma_pkg: shared FSM states, control register map and constants for the DMA read checker
package dma_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    localparam logic [1:0] START    = 2'd0;
    localparam logic [1:0] COUNT_GO = 2'd1;
    localparam logic [1:0] STATUS   = 2'd2;
    localparam logic [1:0] CLEAR    = 2'd3;
    localparam logic [31:0] NO_ERR  = 32'hFFFF_FFFF;
    localparam logic [29:0] ERR_MAX = 30'h3FFF_FFFF;
endpackage

// File: rtl/dma_pattern_check.sv
// dma_pattern_check: compares returned words with an incrementing pattern, counts and locates mismatches
module dma_pattern_check
    import dma_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        valid,
    input  logic [63:0] data,
    output logic [29:0] error_count,
    output logic [31:0] first_err
);
    logic [63:0] expected_q, expected_d;
    logic [31:0] index_q, index_d;
    logic [29:0] error_count_q, error_count_d;
    logic [31:0] first_err_q, first_err_d;
    logic        miss;

    assign miss = valid && (data != expected_q);

    always_comb begin
        expected_d    = init ? 64'd0 : valid ? expected_q + 64'd1 : expected_q;
        index_d       = init ? 32'd0 : valid ? index_q + 32'd1 : index_q;
        error_count_d = init ? 30'd0 : (miss && error_count_q != ERR_MAX) ? error_count_q + 30'd1 : error_count_q;
        first_err_d   = init ? NO_ERR : (miss && first_err_q == NO_ERR) ? index_q : first_err_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            expected_q    <= 64'd0;
            index_q       <= 32'd0;
            error_count_q <= 30'd0;
            first_err_q   <= NO_ERR;
        end else begin
            expected_q    <= expected_d;
            index_q       <= index_d;
            error_count_q <= error_count_d;
            first_err_q   <= first_err_d;
        end
    end

    assign error_count = error_count_q;
    assign first_err   = first_err_q;
endmodule

// File: rtl/dma_read_checker.sv
// dma_read_checker: issues N single-beat 64-bit reads and checks the returned data against an incrementing pattern
module dma_read_checker
    import dma_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ctrl_write,
    input  logic [31:0] ctrl_writedata,
    input  logic        ctrl_read,
    output logic [31:0] ctrl_readdata,
    input  logic [1:0]  ctrl_address,
    output logic        ctrl_waitrequest,
    output logic        master_read,
    output logic [31:0] master_address,
    input  logic [63:0] master_readdata,
    input  logic        master_readdatavalid,
    input  logic        master_waitrequest,
    output logic        master_burstcount,
    output logic [7:0]  master_byteenable,
    output logic        irq
);
    localparam logic [3:0] MAX_O = 4'(MAX_OUTSTANDING);

    state_t      state_q, state_d;
    logic [31:0] start_q, start_d;
    logic [31:0] remaining_q, remaining_d;
    logic [3:0]  outstanding_q, outstanding_d;
    logic [31:0] addr_q, addr_d;
    logic        irq_q, irq_d;
    logic        done_q, done_d;
    logic [31:0] rdata_q, rdata_d;
    logic        busy, accept, rvalid, wr_start, wr_go, wr_clear;
    logic [29:0] error_count;
    logic [31:0] first_err;

    assign busy     = (state_q == ISSUE) || (state_q == DRAIN);
    assign master_read = (state_q == ISSUE) && (remaining_q != 32'd0) && (outstanding_q < MAX_O);
    assign accept   = master_read && !master_waitrequest;
    assign rvalid   = master_readdatavalid && busy;
    assign wr_start = ctrl_write && (ctrl_address == START) && !busy;
    assign wr_go    = ctrl_write && (ctrl_address == COUNT_GO) && !busy;
    assign wr_clear = ctrl_write && (ctrl_address == CLEAR);

    always_comb begin
        state_d       = state_q;
        start_d       = wr_start ? {ctrl_writedata[31:3], 3'b000} : start_q;
        remaining_d   = accept ? remaining_q - 32'd1 : remaining_q;
        addr_d        = accept ? addr_q + 32'd8 : addr_q;
        outstanding_d = (accept && !rvalid) ? outstanding_q + 4'd1 :
                        (!accept && rvalid) ? outstanding_q - 4'd1 : outstanding_q;
        irq_d         = wr_clear ? 1'b0 : irq_q;
        done_d        = wr_clear ? 1'b0 : done_q;
        if (wr_clear && state_q == DONE)
            state_d = IDLE;
        // DONE entry is evaluated last so it wins over a simultaneous clear
        case (state_q)
            ISSUE: if (accept && remaining_q == 32'd1) state_d = DRAIN;
            DRAIN: begin
                if (outstanding_q == 4'd0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    irq_d   = 1'b1;
                end
            end
            default: begin
                if (wr_go) begin
                    remaining_d   = ctrl_writedata;
                    addr_d        = start_q;
                    outstanding_d = 4'd0;
                    state_d       = (ctrl_writedata == 32'd0) ? DONE : ISSUE;
                    done_d        = (ctrl_writedata == 32'd0);
                    irq_d         = (ctrl_writedata == 32'd0) || irq_q;
                end
            end
        endcase
        rdata_d = !ctrl_read ? rdata_q :
                  (ctrl_address == START)    ? start_q :
                  (ctrl_address == COUNT_GO) ? remaining_q :
                  (ctrl_address == STATUS)   ? {busy, done_q, error_count} : first_err;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            start_q       <= 32'd0;
            remaining_q   <= 32'd0;
            outstanding_q <= 4'd0;
            addr_q        <= 32'd0;
            irq_q         <= 1'b0;
            done_q        <= 1'b0;
            rdata_q       <= 32'd0;
        end else begin
            state_q       <= state_d;
            start_q       <= start_d;
            remaining_q   <= remaining_d;
            outstanding_q <= outstanding_d;
            addr_q        <= addr_d;
            irq_q         <= irq_d;
            done_q        <= done_d;
            rdata_q       <= rdata_d;
        end
    end

    dma_pattern_check u_check (
        .clk         (clk),
        .reset       (reset),
        .init        (wr_go),
        .valid       (rvalid),
        .data        (master_readdata),
        .error_count (error_count),
        .first_err   (first_err)
    );

    assign ctrl_readdata     = rdata_q;
    assign ctrl_waitrequest  = 1'b0;
    assign master_address    = addr_q;
    assign master_burstcount = 1'b1;
    assign master_byteenable = 8'hFF;
    assign irq               = irq_q;
endmodule

// File: tb/tb_dma_read_checker.sv
// tb_dma_read_checker: directed runs against a queue-based memory slave model with per-cycle protocol checks
module tb_dma_read_checker;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_write = 1'b0;
    logic [31:0] ctrl_writedata = 32'd0;
    logic        ctrl_read = 1'b0;
    logic [31:0] ctrl_readdata;
    logic [1:0]  ctrl_address = 2'd0;
    logic        ctrl_waitrequest;
    logic        master_read;
    logic [31:0] master_address;
    logic [63:0] master_readdata = 64'd0;
    logic        master_readdatavalid = 1'b0;
    logic        master_waitrequest = 1'b0;
    logic        master_burstcount;
    logic [7:0]  master_byteenable;
    logic        irq;

    dma_read_checker #(.MAX_OUTSTANDING(4)) dut (
        .clk                  (clk),
        .reset                (reset),
        .ctrl_write           (ctrl_write),
        .ctrl_writedata       (ctrl_writedata),
        .ctrl_read            (ctrl_read),
        .ctrl_readdata        (ctrl_readdata),
        .ctrl_address         (ctrl_address),
        .ctrl_waitrequest     (ctrl_waitrequest),
        .master_read          (master_read),
        .master_address       (master_address),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid),
        .master_waitrequest   (master_waitrequest),
        .master_burstcount    (master_burstcount),
        .master_byteenable    (master_byteenable),
        .irq                  (irq)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int acc_cnt = 0, val_cnt = 0, model_n = 0, lat = 0, peak = 0, cyc = 0, bad_idx = -1;
    logic [31:0] model_start = 32'd0;
    logic [63:0] bad_val = 64'd0;
    bit run_active = 0, stall_mode = 0, inject = 0, stalled_prev = 0;
    logic [31:0] addr_prev = 32'd0;
    int due_q[$];
    logic [31:0] addr_log[$];
    logic [31:0] rd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Slave model: records accepts and schedules in-order returns lat cycles later
    always @(posedge clk) begin
        if (reset) begin
            due_q.delete();
            stalled_prev = 0;
        end else begin
            if (master_readdatavalid && due_q.size() > 0) void'(due_q.pop_front());
            if (master_readdatavalid && run_active) val_cnt++;
            cyc++;
            stalled_prev = master_read && master_waitrequest;
            addr_prev = master_address;
            if (master_read && !master_waitrequest) begin
                due_q.push_back(cyc + lat);
                addr_log.push_back(master_address);
                acc_cnt++;
            end
            if (acc_cnt - val_cnt > peak) peak = acc_cnt - val_cnt;
        end
    end

    always @(negedge clk) begin
        master_waitrequest = stall_mode ? ($urandom_range(1) == 1) : 1'b0;
        if (inject) begin
            master_readdatavalid = 1'b1;
            master_readdata = 64'hBAD;
        end else if (!reset && due_q.size() > 0 && due_q[0] <= cyc) begin
            master_readdatavalid = 1'b1;
            master_readdata = (val_cnt == bad_idx) ? bad_val : 64'(val_cnt);
        end else begin
            master_readdatavalid = 1'b0;
            master_readdata = 64'd0;
        end
        if (!reset) begin
            if (stalled_prev) begin
                check("stall_read", master_read, 1);
                check("stall_addr", master_address, addr_prev);
            end
            if (master_read) begin
                check("issue_addr", master_address, model_start + 32'(8 * acc_cnt));
                check("issue_window", (acc_cnt - val_cnt < 4) && (acc_cnt < model_n), 1);
                check("burst_be", {master_burstcount, master_byteenable}, 9'h1FF);
            end
            if (run_active && val_cnt < model_n) check("irq_early", irq, 0);
        end
    end

    task automatic ctrl_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        ctrl_write = 1'b1;
        ctrl_address = a;
        ctrl_writedata = d;
        @(negedge clk);
        ctrl_write = 1'b0;
    endtask

    task automatic ctrl_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        ctrl_read = 1'b1;
        ctrl_address = a;
        @(negedge clk);
        ctrl_read = 1'b0;
        d = ctrl_readdata;
    endtask

    task automatic start_run(input logic [31:0] st, input int n, input int l, input bit stall,
                             input int bi, input logic [63:0] bv);
        ctrl_wr(2'd3, 32'd0);
        acc_cnt = 0; val_cnt = 0; peak = 0; addr_log.delete();
        lat = l; stall_mode = stall; bad_idx = bi; bad_val = bv;
        model_start = {st[31:3], 3'b000}; model_n = n; run_active = 1;
        ctrl_wr(2'd0, st);
        ctrl_wr(2'd1, 32'(n));
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (irq) break;
            @(negedge clk);
        end
        check("done_timeout", irq, 1);
        check("accepts", acc_cnt, model_n);
        check("valids", val_cnt, model_n);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_read", master_read, 0);
        check("rst_addr", master_address, 0);
        check("rst_rdata", ctrl_readdata, 0);
        check("rst_irq", irq, 0);
        reset = 1'b0;
        ctrl_rd(2'd2, rd); check("rst_status", rd, 32'h0);
        ctrl_rd(2'd3, rd); check("rst_first_err", rd, 32'hFFFF_FFFF);
        check("ctrl_wait", ctrl_waitrequest, 0);
        ctrl_wr(2'd0, 32'h0000_1007);
        ctrl_rd(2'd0, rd); check("start_align", rd, 32'h0000_1000);

        start_run(32'h1000, 4, 0, 0, -1, 64'd0);
        wait_done(200);
        check("t1_addr0", addr_log[0], 32'h1000);
        check("t1_addr1", addr_log[1], 32'h1008);
        check("t1_addr2", addr_log[2], 32'h1010);
        check("t1_addr3", addr_log[3], 32'h1018);
        ctrl_rd(2'd2, rd); check("t1_status", rd, 32'h4000_0000);
        ctrl_rd(2'd3, rd); check("t1_first_err", rd, 32'hFFFF_FFFF);
        ctrl_rd(2'd1, rd); check("t1_remaining", rd, 32'd0);
        ctrl_wr(2'd3, 32'd0);
        check("t1_irq_clear", irq, 0);
        ctrl_rd(2'd2, rd); check("t1_status_clear", rd, 32'h0);

        start_run(32'h2000, 8, 0, 0, 5, 64'hDEAD);
        wait_done(200);
        ctrl_rd(2'd2, rd); check("t2_status", rd, 32'h4000_0001);
        ctrl_rd(2'd3, rd); check("t2_first_err", rd, 32'd5);

        start_run(32'h0, 16, 10, 0, -1, 64'd0);
        wait_done(500);
        check("t3_peak", peak, 4);
        ctrl_rd(2'd2, rd); check("t3_status", rd, 32'h4000_0000);

        start_run(32'h5000, 12, 0, 1, -1, 64'd0);
        wait_done(1000);
        check("t4_last_addr", addr_log[11], 32'h5058);
        ctrl_rd(2'd2, rd); check("t4_status", rd, 32'h4000_0000);

        start_run(32'h6000, 0, 0, 0, -1, 64'd0);
        check("t5_irq_next", irq, 1);
        check("t5_no_read", acc_cnt, 0);
        ctrl_rd(2'd2, rd); check("t5_status", rd, 32'h4000_0000);

        start_run(32'h3000, 20, 10, 0, -1, 64'd0);
        ctrl_wr(2'd1, 32'd5);
        ctrl_wr(2'd0, 32'h9000);
        ctrl_rd(2'd0, rd); check("t5_busy_start", rd, 32'h3000);
        wait_done(1000);
        ctrl_rd(2'd1, rd); check("t5_busy_remaining", rd, 32'd0);

        start_run(32'h4000, 4, 10, 0, -1, 64'd0);
        for (int i = 0; i < 200 && acc_cnt < 4; i++) @(negedge clk);
        check("t6_reach_drain", acc_cnt, 4);
        @(negedge clk);
        #2 reset = 1'b1;
        run_active = 0;
        #1;
        check("t6_rst_read", master_read, 0);
        check("t6_rst_addr", master_address, 0);
        check("t6_rst_rdata", ctrl_readdata, 0);
        check("t6_rst_irq", irq, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1 inject = 1;
        @(posedge clk); #1 inject = 0;
        ctrl_rd(2'd2, rd); check("t6_status", rd, 32'h0);
        ctrl_rd(2'd3, rd); check("t6_first_err", rd, 32'hFFFF_FFFF);
        ctrl_rd(2'd0, rd); check("t6_start", rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dma_read_checker.md
DMA_READ_CHECKER -- requirements
Module: dma_read_checker

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, meaning the maximum number of accepted but unreturned master reads (legal range 1..15).
REQ-002 SHALL have port clk, input, 1, the single clock for all logic.
REQ-003 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port ctrl_write, input, 1, control-slave write strobe.
REQ-005 SHALL have port ctrl_writedata, input, 32, control-slave write data.
REQ-006 SHALL have port ctrl_read, input, 1, control-slave read strobe.
REQ-007 SHALL have port ctrl_readdata, output, 32, control-slave read data.
REQ-008 SHALL have port ctrl_address, input, 2, control register select.
REQ-009 SHALL have port ctrl_waitrequest, output, 1, tied 0.
REQ-010 SHALL have port master_read, output, 1, memory read request.
REQ-011 SHALL have port master_address, output, 32, byte address of the read.
REQ-012 SHALL have port master_readdata, input, 64, returned read data.
REQ-013 SHALL have port master_readdatavalid, input, 1, qualifies master_readdata.
REQ-014 SHALL have port master_waitrequest, input, 1, stalls the read request.
REQ-015 SHALL have ports master_burstcount (output, 1, constant 1) and master_byteenable (output, 8, constant 8'hFF).
REQ-016 SHALL have port irq, output, 1, completion interrupt, level, held until cleared.

Function
REQ-017 SHALL decode ctrl writes: addr 0 = start address (bits [2:0] forced 0); addr 1 = word count N plus start; addr 3 = clear irq and done; addr 2 writes ignored.
REQ-018 SHALL return on ctrl_read, one cycle later (read latency 1): addr 0 = start address; addr 1 = words remaining to issue; addr 2 = {busy[31], done[30], error_count[29:0]}; addr 3 = index of the first mismatching word (32'hFFFF_FFFF if none).
REQ-019 SHALL use states IDLE, ISSUE, DRAIN, DONE.
REQ-020 SHALL, on an addr 1 write in IDLE or DONE, load N, copy the start address to master_address, clear expected data to 0, error_count to 0, first-error to all ones and done to 0, and go to ISSUE; if N = 0, go directly to DONE.
REQ-021 SHALL ignore an addr 0 or addr 1 write while busy (ISSUE or DRAIN).
REQ-022 SHALL assert master_read in ISSUE only while remaining > 0 and outstanding < MAX_OUTSTANDING; the request is accepted when master_read and not master_waitrequest.
REQ-023 SHALL hold master_read and master_address stable while master_waitrequest is high.
REQ-024 SHALL, on each accepted read, add 8 to master_address (32-bit wrap) and decrement remaining; leave ISSUE for DRAIN when remaining reaches 0.
REQ-025 SHALL keep the outstanding count as +1 on accept, -1 on readdatavalid, unchanged if both occur in the same cycle.
REQ-026 SHALL compare each valid master_readdata with the 64-bit expected value, then increment expected by 1 (64-bit wrap).
REQ-027 SHALL, on a mismatch, increment error_count (saturating at 2^30-1) and record the word index on the first mismatch only.
REQ-028 SHALL move DRAIN to DONE when outstanding is 0, set done and set irq in the same transition.
REQ-029 SHALL ignore master_readdatavalid in IDLE and DONE.
REQ-030 SHALL clear irq and done on an addr 3 write and return to IDLE; a clear and a DONE-entry in the same cycle leave irq set.

Reset
REQ-031 SHALL, on reset, drive master_read 0, master_address 0, ctrl_readdata 0, irq 0, state IDLE, all counters 0, and first-error all ones.
REQ-032 SHALL abandon any transfer when reset is asserted mid-operation; data returned after reset is ignored.

Structure
REQ-033 SHALL place the state enumeration and the register address constants (START, COUNT_GO, STATUS, CLEAR) in the shared package dma_pkg.
REQ-034 SHALL implement the compare, error counter and first-error capture as one sub-module, dma_pattern_check.

Verification
REQ-035 SHALL cover: start 0x1000, N=4, zero-latency slave returning 0..3 -> reads at 0x1000, 0x1008, 0x1010, 0x1018; irq set; status = 0x4000_0000.
REQ-036 SHALL cover: N=8, slave returns word 5 as 0xDEAD -> error_count 1, addr 3 reads 5.
REQ-037 SHALL cover: N=16, slave latency 10 cycles, MAX_OUTSTANDING=4 -> master_read never asserted with 4 outstanding; DONE only after the 16th valid.
REQ-038 SHALL cover: random master_waitrequest -> address and read stable while stalled; exactly N accepts.
REQ-039 SHALL cover: N=0 -> irq next cycle with no master_read; an addr 1 write while busy has no effect.
REQ-040 SHALL cover: reset asserted during DRAIN -> all outputs at reset values; a late readdatavalid does not change error_count.
